mem_initiator: RTL

- Command-driven initiator for the 128x8 single-port RAM: 7-bit address, 8-bit data, write enable.
- The RAM writes and registers its read data on the falling clock edge.
- This block accepts single and burst read/write commands from the datapath over a valid/ready handshake and sequences the RAM port.
- Read data is returned on a valid/ready stream with backpressure; the block sits between the control FSM and the RAM.

---
 rtl/mem_initiator.sv | 109 ++++++++++
 1 files changed

// File: rtl/mem_initiator.sv
// Command-driven initiator for a falling-edge single-port RAM.
// Sequences single/burst reads and writes; read data leaves on a valid/ready stream.
module mem_initiator #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_BURST = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_HOLD
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   remaining;
    logic                is_wr_op;
    logic                is_len_op;

    assign is_wr_op  = (cmd_op == OP_WRITE) || (cmd_op == OP_FILL);
    assign is_len_op = (cmd_op == OP_FILL) || (cmd_op == OP_BURST);

    // mem_addr doubles as the current address so the RAM sees it straight from a flop
    assign busy      = (state != IDLE);
    assign cmd_ready = (state == IDLE) && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        mem_addr  <= cmd_addr;
                        mem_din   <= cmd_data;
                        remaining <= is_len_op ? cmd_len : '0;
                        if (is_wr_op) begin
                            mem_we <= 1'b1;
                            state  <= WR;
                        end else begin
                            state  <= RD_ISSUE;
                        end
                    end
                end
                WR: begin
                    if (remaining == '0) begin
                        mem_we <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        remaining <= remaining - ADDR_W'(1);
                    end
                end
                RD_ISSUE: begin
                    rd_data  <= mem_dout;
                    rd_valid <= 1'b1;
                    state    <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (remaining == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            remaining <= remaining - ADDR_W'(1);
                            state     <= RD_ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
